fb_pixel_writer: RTL and testbench
==================================

FB_PIXEL_WRITER -- requirements
Module: fb_pixel_writer

Interface
REQ-001 Parameter FB_WIDTH, default 320, framebuffer row pitch in pixels.
REQ-002 Parameter FB_HEIGHT, default 240, framebuffer rows.
REQ-003 Parameter FIFO_DEPTH, default 16, pixel FIFO entries (power of two, 4..64).
REQ-004 Port i_clk  input  1  sole clock, rising edge.
REQ-005 Port i_reset  input  1  synchronous, active-high reset.
REQ-006 Port i_write_pixel  input  1  pixel strobe from raster output; no backpressure upstream.
REQ-007 Port i_x  input  16 signed  pixel column.
REQ-008 Port i_y  input  16 signed  pixel row.
REQ-009 Port i_color_r / i_color_g / i_color_b  input  8 each  pixel colour.
REQ-010 Port o_mem_valid  output  1  memory write request valid.
REQ-011 Port i_mem_ready  input  1  memory accepts request this cycle.
REQ-012 Port o_mem_addr  output  17  pixel word address.
REQ-013 Port o_mem_data  output  16  RGB565 pixel word.
REQ-014 Port o_level  output  7  current FIFO occupancy.
REQ-015 Port o_idle  output  1  FIFO empty and o_mem_valid low.
REQ-016 Port o_overflow  output  1  sticky: at least one pixel dropped.
REQ-017 Port i_clear_overflow  input  1  clears o_overflow.
REQ-018 Port o_clip_count  output  16  pixels discarded by bounds check.

Function
REQ-019 Address = i_y*FB_WIDTH + i_x, computed on push, truncated to 17 bits (two's-complement wrap).
REQ-020 Data = {r[7:3], g[7:2], b[7:3]}, computed on push.
REQ-021 Push occurs when i_write_pixel=1 and (FIFO not full or a pop occurs the same cycle).
REQ-022 i_write_pixel=1 with FIFO full and no same-cycle pop: pixel dropped, o_overflow set next cycle.
REQ-023 o_overflow cleared by i_clear_overflow; simultaneous drop and clear leaves o_overflow=1.
REQ-024 Output stage FSM: OUT_EMPTY (o_mem_valid=0), OUT_VALID (o_mem_valid=1).
REQ-025 OUT_EMPTY -> OUT_VALID when FIFO non-empty; head popped into output register.
REQ-026 OUT_VALID with i_mem_ready=1: reload from FIFO if non-empty (stay OUT_VALID), else -> OUT_EMPTY.
REQ-027 OUT_VALID with i_mem_ready=0: o_mem_addr/o_mem_data held stable, no pop.
REQ-028 Latency: pixel pushed at edge N into empty FIFO/idle output shows o_mem_valid=1 after edge N+1.
REQ-029 Throughput: one request per cycle sustained while i_mem_ready=1.
REQ-030 Order preserved; every accepted pixel issued exactly once.
REQ-031 o_level counts FIFO entries only (excludes output register); push+pop same cycle leaves it unchanged.

Reset
REQ-032 On i_reset: FIFO emptied, FSM to OUT_EMPTY, o_mem_valid=0, o_mem_addr=0, o_mem_data=0, o_level=0, o_overflow=0, o_clip_count=0, o_idle=1.
REQ-033 Reset mid-burst discards pending pixels and any unaccepted request; i_write_pixel ignored during reset cycle.

Configuration
REQ-034 Macro FB_PIXEL_WRITER_BOUNDS_CHECK_EN defined: pixels with i_x<0, i_x>=FB_WIDTH, i_y<0 or i_y>=FB_HEIGHT not pushed, not counted as overflow; o_clip_count increments, saturating at 65535.
REQ-035 Macro undefined: no bounds check, all pixels subject to REQ-019 wrap; o_clip_count tied 0.

Verification
REQ-036 Single pixel x=10,y=2,r=0xFF,g=0x80,b=0x08, ready=1 -> o_mem_valid after 2 edges, addr=650, data=0xFC01, o_idle=1 after.
REQ-037 17 consecutive strobes, ready=0 (depth 16) -> 1 in output reg, 16 in FIFO, o_level=16, o_overflow=0; 18th strobe -> o_overflow=1, 17 requests issued in order on release.
REQ-038 Ready toggling 1,0,1,0 over 8 pixels -> addr/data stable while stalled, 8 requests in order, none duplicated.
REQ-039 With BOUNDS_CHECK_EN: x=320,y=0 and x=-1,y=5 -> no request, o_clip_count=2; without: x=320,y=0 -> addr=320.
REQ-040 Reset asserted with 5 pending pixels and valid stalled -> next cycle o_mem_valid=0, o_level=0, o_idle=1.

Source files
------------

// File: rtl/fb_pixel_writer_if.sv
// ---------------------------------------------------------------------------
// fb_pixel_writer_if
//
// Purpose: memory write-request bus between the framebuffer pixel writer and
// the framebuffer memory. One request is transferred on every rising clock
// edge where mem_valid and mem_ready are both high.
//
// Signals:
//   mem_valid  request valid (driven by the writer)
//   mem_ready  memory accepts the request this cycle (driven by the memory)
//   mem_addr   17-bit pixel word address
//   mem_data   16-bit RGB565 pixel word
//
// Modports:
//   master  the pixel writer (drives valid/addr/data, samples ready)
//   slave   the memory side (samples valid/addr/data, drives ready)
// ---------------------------------------------------------------------------
interface fb_pixel_writer_if;
  logic        mem_valid;
  logic        mem_ready;
  logic [16:0] mem_addr;
  logic [15:0] mem_data;

  modport master (
    output mem_valid,
    output mem_addr,
    output mem_data,
    input  mem_ready
  );

  modport slave (
    input  mem_valid,
    input  mem_addr,
    input  mem_data,
    output mem_ready
  );
endinterface

// File: rtl/fb_pixel_writer.sv
// ---------------------------------------------------------------------------
// fb_pixel_writer
//
// Purpose: accepts pixel strobes from a raster stage (no upstream
// backpressure), converts each pixel into a framebuffer word address and an
// RGB565 data word, buffers them in a small FIFO and issues them as memory
// write requests over a valid/ready bus. Pixels arriving while the FIFO is
// full (with no same-cycle pop) are dropped and flagged with a sticky
// overflow bit.
//
// Parameters:
//   FB_WIDTH    framebuffer row pitch in pixels
//   FB_HEIGHT   framebuffer rows (only used by the optional bounds check)
//   FIFO_DEPTH  pixel FIFO entries, power of two in 4..64
//
// Ports:
//   i_clk              sole clock, rising edge
//   i_reset            synchronous active-high reset
//   i_write_pixel      pixel strobe
//   i_x, i_y           signed pixel column / row
//   i_color_r/g/b      8-bit colour components
//   mem                memory write bus (master side)
//   o_level            FIFO occupancy (output register not included)
//   o_idle             FIFO empty and no request outstanding
//   o_overflow         sticky: at least one pixel dropped
//   i_clear_overflow   clears o_overflow (a same-cycle drop wins)
//   o_clip_count       pixels discarded by the bounds check
//
// Configuration:
//   FB_PIXEL_WRITER_BOUNDS_CHECK_EN  when defined, pixels outside
//   [0,FB_WIDTH) x [0,FB_HEIGHT) are discarded and counted in o_clip_count
//   (saturating). When undefined every pixel is written with a wrapped
//   17-bit address and o_clip_count is tied to zero.
// ---------------------------------------------------------------------------
module fb_pixel_writer #(
  parameter int FB_WIDTH   = 320,
  parameter int FB_HEIGHT  = 240,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_write_pixel,
  input  logic signed [15:0]  i_x,
  input  logic signed [15:0]  i_y,
  input  logic [7:0]          i_color_r,
  input  logic [7:0]          i_color_g,
  input  logic [7:0]          i_color_b,
  fb_pixel_writer_if.master   mem,
  output logic [6:0]          o_level,
  output logic                o_idle,
  output logic                o_overflow,
  input  logic                i_clear_overflow,
  output logic [15:0]         o_clip_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic {
    OUT_EMPTY,
    OUT_VALID
  } out_state_t;

  out_state_t         state;
  out_state_t         state_next;

  logic signed [31:0] full_addr;
  logic [16:0]        push_addr;
  logic [15:0]        push_data;
  logic               in_bounds;

  logic [32:0]        fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [6:0]         count;
  logic               fifo_empty;
  logic               fifo_full;
  logic               push;
  logic               pop;
  logic               drop;
  logic [32:0]        head;

  logic               out_valid;
  logic [16:0]        out_addr;
  logic [15:0]        out_data;

  // Pixel formatting. The address is computed in 32-bit signed arithmetic and
  // then truncated, so negative or oversized coordinates wrap modulo 2^17.
  always_comb begin
    full_addr = 32'(i_y) * FB_WIDTH + 32'(i_x);
  end

  assign push_addr = full_addr[16:0];
  assign push_data = {i_color_r[7:3], i_color_g[7:2], i_color_b[7:3]};

  // Colour LSBs and the upper address bits are discarded by construction.
  logic unused_bits;
  assign unused_bits = ^{full_addr[31:17], i_color_r[2:0], i_color_g[1:0], i_color_b[2:0]};

`ifdef FB_PIXEL_WRITER_BOUNDS_CHECK_EN
  logic [15:0] clip_count;

  assign in_bounds = (32'(i_x) >= 0) && (32'(i_x) < FB_WIDTH) &&
                     (32'(i_y) >= 0) && (32'(i_y) < FB_HEIGHT);

  // Clipped pixels never reach the FIFO, so they cannot cause an overflow;
  // they are only counted, and the count sticks at its maximum.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      clip_count <= 16'd0;
    end else if (i_write_pixel && !in_bounds && (clip_count != 16'hFFFF)) begin
      clip_count <= clip_count + 16'd1;
    end
  end

  assign o_clip_count = clip_count;
`else
  assign in_bounds    = 1'b1;
  assign o_clip_count = 16'd0;

  // The row count only matters when bounds checking is compiled in.
  logic unused_config;
  assign unused_config = (FB_HEIGHT > 0);
`endif

  assign fifo_empty = (count == 7'd0);
  assign fifo_full  = (count == 7'(FIFO_DEPTH));
  assign head       = fifo_mem[rd_ptr];

  // A full FIFO still accepts a pixel when the output stage pops the head in
  // the same cycle, so the slot being vacated is reused immediately.
  assign push = i_write_pixel && in_bounds && (!fifo_full || pop);
  assign drop = i_write_pixel && in_bounds && fifo_full && !pop;

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge i_clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {push_addr, push_data};
    end
  end

  // FIFO pointers and occupancy. Push and pop together leave the count alone.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= 7'd0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 7'd1;
        2'b01:   count <= count - 7'd1;
        default: count <= count;
      endcase
    end
  end

  // Output stage state register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= OUT_EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // Output stage next-state logic. A completed handshake with data waiting
  // reloads the output register and stays valid, giving one request per cycle.
  always_comb begin
    state_next = state;
    unique case (state)
      OUT_EMPTY: begin
        if (!fifo_empty) begin
          state_next = OUT_VALID;
        end
      end
      OUT_VALID: begin
        if (mem.mem_ready && fifo_empty) begin
          state_next = OUT_EMPTY;
        end
      end
      default: state_next = OUT_EMPTY;
    endcase
  end

  // Output stage outputs. The head is popped whenever the output register is
  // free or is being consumed this cycle; a stalled request blocks popping.
  always_comb begin
    out_valid = 1'b0;
    pop       = 1'b0;
    unique case (state)
      OUT_EMPTY: begin
        pop = !fifo_empty;
      end
      OUT_VALID: begin
        out_valid = 1'b1;
        pop       = !fifo_empty && mem.mem_ready;
      end
      default: begin
        out_valid = 1'b0;
        pop       = 1'b0;
      end
    endcase
  end

  // Output request register; only changes on a pop, so a stalled request
  // keeps its address and data stable.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      out_addr <= 17'd0;
      out_data <= 16'd0;
    end else if (pop) begin
      out_addr <= head[32:16];
      out_data <= head[15:0];
    end
  end

  // Sticky overflow flag; a drop in the same cycle as a clear wins.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_overflow <= 1'b0;
    end else if (drop) begin
      o_overflow <= 1'b1;
    end else if (i_clear_overflow) begin
      o_overflow <= 1'b0;
    end
  end

  assign mem.mem_valid = out_valid;
  assign mem.mem_addr  = out_addr;
  assign mem.mem_data  = out_data;
  assign o_level       = count;
  assign o_idle        = fifo_empty && !out_valid;

endmodule

// File: tb/tb_fb_pixel_writer.sv
// ---------------------------------------------------------------------------
// tb_fb_pixel_writer
//
// Purpose: self-checking bench for fb_pixel_writer. Directed scenarios
// (single pixel, FIFO fill and overflow, stalled handshakes, clipping or
// wrap, reset mid-burst) are followed by a randomized phase. A pixel-count
// reference model predicts acceptance, occupancy and flags; every accepted
// pixel's expected request is queued and a separate monitor compares it
// against each request the memory accepts, in order.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_fb_pixel_writer;

  localparam int FB_W  = 320;
  localparam int FB_H  = 240;
  localparam int DEPTH = 16;

  logic               clk = 1'b0;
  logic               reset;
  logic               write_pixel;
  logic signed [15:0] x_in;
  logic signed [15:0] y_in;
  logic [7:0]         color_r;
  logic [7:0]         color_g;
  logic [7:0]         color_b;
  logic               clear_overflow;
  logic [6:0]         level;
  logic               idle;
  logic               overflow;
  logic [15:0]        clip_count;

  fb_pixel_writer_if mem_bus();

  fb_pixel_writer #(
    .FB_WIDTH   (FB_W),
    .FB_HEIGHT  (FB_H),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .i_clk            (clk),
    .i_reset          (reset),
    .i_write_pixel    (write_pixel),
    .i_x              (x_in),
    .i_y              (y_in),
    .i_color_r        (color_r),
    .i_color_g        (color_g),
    .i_color_b        (color_b),
    .mem              (mem_bus.master),
    .o_level          (level),
    .o_idle           (idle),
    .o_overflow       (overflow),
    .i_clear_overflow (clear_overflow),
    .o_clip_count     (clip_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: pixels accepted but not yet issued (FIFO plus output
  // register), whether a request is being presented, the sticky flag and the
  // clip counter.
  int          pend    = 0;
  bit          m_valid = 1'b0;
  bit          m_ov    = 1'b0;
  int          m_clip  = 0;
  logic [32:0] sb [$];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  function automatic bit inBounds(input int x, input int y);
`ifdef FB_PIXEL_WRITER_BOUNDS_CHECK_EN
    return (x >= 0) && (x < FB_W) && (y >= 0) && (y < FB_H);
`else
    return 1'b1;
`endif
  endfunction

  function automatic int rc();
    return int'($urandom_range(0, 255));
  endfunction

  // Drive one cycle of inputs, advance the model by one clock, then check
  // the DUT's registered status against the model just after the edge.
  task automatic applyStimulus(input bit rst, input bit wr, input int x, input int y,
                               input int cr, input int cg, input int cb,
                               input bit rdy, input bit clr);
    int fifo_n;
    bit pop;
    bit issue;
    bit acc;
    bit inb;
    int a;
    reset             = rst;
    write_pixel       = wr;
    x_in              = 16'(x);
    y_in              = 16'(y);
    color_r           = 8'(cr);
    color_g           = 8'(cg);
    color_b           = 8'(cb);
    mem_bus.mem_ready = rdy;
    clear_overflow    = clr;
    if (rst) begin
      pend    = 0;
      m_valid = 1'b0;
      m_ov    = 1'b0;
      m_clip  = 0;
      sb.delete();
    end else begin
      inb    = inBounds(x, y);
      fifo_n = pend - int'(m_valid);
      pop    = (fifo_n > 0) && (!m_valid || rdy);
      issue  = m_valid && rdy;
      acc    = wr && inb && ((fifo_n < DEPTH) || pop);
      if (acc) begin
        a = y * FB_W + x;
        sb.push_back({17'(a), 16'(((cr >> 3) << 11) | ((cg >> 2) << 5) | (cb >> 3))});
      end
      if (wr && inb && !acc) begin
        m_ov = 1'b1;
      end else if (clr) begin
        m_ov = 1'b0;
      end
      if (wr && !inb && (m_clip < 65535)) begin
        m_clip++;
      end
      pend    = pend + int'(acc) - int'(issue);
      m_valid = pop || (m_valid && !rdy);
    end
    @(posedge clk);
    #1;
    checkOutput("mem_valid", 32'(mem_bus.mem_valid), 32'(m_valid));
    checkOutput("level", 32'(level), 32'(pend - int'(m_valid)));
    checkOutput("idle", 32'(idle), 32'(pend == 0));
    checkOutput("overflow", 32'(overflow), 32'(m_ov));
    checkOutput("clip_count", 32'(clip_count), 32'(m_clip));
  endtask

  // Let the memory accept everything still pending, bounded in cycles.
  task automatic drainAll(input string tag);
    for (int k = 0; (k < 200) && (pend != 0); k++) begin
      applyStimulus(1'b0, 1'b0, 0, 0, 0, 0, 0, 1'b1, 1'b0);
    end
    checkOutput({tag, "_idle"}, 32'(idle), 32'd1);
    checkOutput({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
  endtask

  // Monitor: compares each accepted request against the head of the expected
  // queue, and checks that a stalled request holds its address and data.
  logic [32:0] exp_req;
  logic [32:0] held;
  bit          have_held = 1'b0;

  always @(negedge clk) begin
    if (reset !== 1'b0) begin
      have_held = 1'b0;
    end else begin
      if (have_held && (mem_bus.mem_valid === 1'b1)) begin
        checkOutput("stall_addr", 32'(mem_bus.mem_addr), 32'(held[32:16]));
        checkOutput("stall_data", 32'(mem_bus.mem_data), 32'(held[15:0]));
      end
      have_held = 1'b0;
      if ((mem_bus.mem_valid === 1'b1) && (mem_bus.mem_ready === 1'b1)) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_request actual=%0h/%0h required=none",
                   mem_bus.mem_addr, mem_bus.mem_data);
        end else begin
          exp_req = sb.pop_front();
          checkOutput("req_addr", 32'(mem_bus.mem_addr), 32'(exp_req[32:16]));
          checkOutput("req_data", 32'(mem_bus.mem_data), 32'(exp_req[15:0]));
        end
      end else if ((mem_bus.mem_valid === 1'b1) && (mem_bus.mem_ready === 1'b0)) begin
        held      = {mem_bus.mem_addr, mem_bus.mem_data};
        have_held = 1'b1;
      end
    end
  end

  // Main stimulus sequence.
  initial begin
    int x;
    int y;
    int rdy_pct;

    $display("[TB] start");
    applyStimulus(1'b1, 1'b0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 5, 5, 1, 2, 3, 1'b0, 1'b0);
    checkOutput("reset_addr", 32'(mem_bus.mem_addr), 32'd0);
    checkOutput("reset_data", 32'(mem_bus.mem_data), 32'd0);

    // Single pixel, memory always ready.
    applyStimulus(1'b0, 1'b1, 10, 2, 'hFF, 'h80, 'h08, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 0, 0, 0, 0, 0, 1'b1, 1'b0);
    checkOutput("single_addr", 32'(mem_bus.mem_addr), 32'd650);
    checkOutput("single_data", 32'(mem_bus.mem_data), 32'h0000_FC01);
    drainAll("single");

    // Fill output register plus FIFO with the memory stalled, then overflow.
    for (int i = 0; i < DEPTH + 1; i++) begin
      applyStimulus(1'b0, 1'b1, i * 3, 7, rc(), rc(), rc(), 1'b0, 1'b0);
    end
    checkOutput("burst_level", 32'(level), 32'(DEPTH));
    checkOutput("burst_no_overflow", 32'(overflow), 32'd0);
    applyStimulus(1'b0, 1'b1, 99, 9, rc(), rc(), rc(), 1'b0, 1'b0);
    checkOutput("burst_overflow", 32'(overflow), 32'd1);
    drainAll("burst");
    applyStimulus(1'b0, 1'b0, 0, 0, 0, 0, 0, 1'b1, 1'b1);

    // Drop and clear in the same cycle: the drop must win.
    for (int i = 0; i < DEPTH + 1; i++) begin
      applyStimulus(1'b0, 1'b1, 200 - i, 100, rc(), rc(), rc(), 1'b0, 1'b0);
    end
    applyStimulus(1'b0, 1'b1, 1, 1, rc(), rc(), rc(), 1'b0, 1'b1);
    checkOutput("drop_beats_clear", 32'(overflow), 32'd1);
    drainAll("dropclr");
    applyStimulus(1'b0, 1'b0, 0, 0, 0, 0, 0, 1'b1, 1'b1);

    // Ready toggling while pixels stream in and drain.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 1'b1, i * 11, 20 + i, rc(), rc(), rc(), (i % 2) == 0, 1'b0);
    end
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 1'b0, 0, 0, 0, 0, 0, (i % 2) == 0, 1'b0);
    end
    drainAll("toggle");

    // Right edge and negative column: clipped or wrapped depending on build.
    applyStimulus(1'b0, 1'b1, FB_W, 0, rc(), rc(), rc(), 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, -1, 5, rc(), rc(), rc(), 1'b1, 1'b0);
`ifdef FB_PIXEL_WRITER_BOUNDS_CHECK_EN
    checkOutput("clip_two", 32'(clip_count), 32'd2);
    applyStimulus(1'b0, 1'b1, 0, FB_H, rc(), rc(), rc(), 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, FB_W - 1, FB_H - 1, rc(), rc(), rc(), 1'b1, 1'b0);
`else
    checkOutput("clip_zero", 32'(clip_count), 32'd0);
    applyStimulus(1'b0, 1'b1, -5, -3, rc(), rc(), rc(), 1'b1, 1'b0);
`endif
    drainAll("edges");

    // Randomized phase, alternating between a fast and a slow memory.
    for (int k = 0; k < 600; k++) begin
      rdy_pct = (((k / 100) % 2) == 1) ? 2 : 8;
      if ($urandom_range(0, 9) < 8) begin
        x = int'($urandom_range(0, FB_W - 1));
        y = int'($urandom_range(0, FB_H - 1));
      end else begin
        x = int'($urandom_range(0, 800)) - 400;
        y = int'($urandom_range(0, 600)) - 300;
      end
      applyStimulus(1'b0, $urandom_range(0, 9) < 7, x, y, rc(), rc(), rc(),
                    $urandom_range(0, 9) < rdy_pct, $urandom_range(0, 19) == 0);
    end
    drainAll("random");

    // Reset with pending pixels and a stalled request; the strobe is ignored.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b1, 40 + i, 60, rc(), rc(), rc(), 1'b0, 1'b0);
    end
    checkOutput("prereset_level", 32'(level), 32'd4);
    applyStimulus(1'b1, 1'b1, 3, 3, rc(), rc(), rc(), 1'b0, 1'b0);
    checkOutput("postreset_valid", 32'(mem_bus.mem_valid), 32'd0);
    checkOutput("postreset_level", 32'(level), 32'd0);
    checkOutput("postreset_idle", 32'(idle), 32'd1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, 0, 0, 0, 0, 0, 1'b1, 1'b0);
    end
    applyStimulus(1'b0, 1'b1, 17, 4, rc(), rc(), rc(), 1'b1, 1'b0);
    drainAll("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
